// File: rtl/snake_step_scheduler.sv
// Snake step scheduler: divides CLK into move ticks, issues one step request
// per tick over a REQ/ACK handshake, and filters player direction input so
// the snake can never reverse onto itself. The tick period shrinks as the
// score rises, down to a floor.
module snake_step_scheduler #(
    parameter int unsigned BASE_PERIOD = 5000000,
    parameter int unsigned PERIOD_DEC  = 400000,
    parameter int unsigned MIN_PERIOD  = 1000000,
    parameter int unsigned CNT_W       = 23
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  MASTER_STATE,
    input  logic [3:0]  SCORE_COUNT,
    input  logic        BTN_UP,
    input  logic        BTN_RIGHT,
    input  logic        BTN_DOWN,
    input  logic        BTN_LEFT,
    input  logic        STEP_ACK,
    output logic        STEP_REQ,
    output logic [1:0]  STEP_DIR,
    output logic [1:0]  DIRECTION,
    output logic [15:0] STEP_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_REQ,
        S_HOLD
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Headroom between base period and floor; decrement beyond this saturates.
    localparam int unsigned PERIOD_SPAN = BASE_PERIOD - MIN_PERIOD;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [CNT_W-1:0]  period_m1_q, period_m1_d;
    logic [1:0]        pending_q, pending_d;
    logic              step_req_q, step_req_d;
    logic [1:0]        step_dir_q, step_dir_d;
    logic [1:0]        direction_q, direction_d;
    logic [15:0]       step_count_q, step_count_d;

    logic              mode_play;
    logic              mode_win;
    logic              mode_idle;
    logic              btn_any;
    logic [1:0]        btn_dir;
    logic              capture_ok;
    logic              handshake;
    logic [31:0]       score_sat;
    logic [31:0]       dec_total;
    logic [31:0]       period_full;
    logic [CNT_W-1:0]  period_m1_next;

    // Master state decode; the unused encoding 3 behaves as IDLE.
    always_comb begin
        mode_play = (MASTER_STATE == 2'd1);
        mode_win  = (MASTER_STATE == 2'd2);
        mode_idle = (MASTER_STATE == 2'd0) || (MASTER_STATE == 2'd3);
    end

    // Button priority encoder (UP > RIGHT > DOWN > LEFT) and reversal filter.
    always_comb begin
        btn_any = BTN_UP | BTN_RIGHT | BTN_DOWN | BTN_LEFT;
        btn_dir = DIR_UP;
        if (BTN_UP) begin
            btn_dir = DIR_UP;
        end else if (BTN_RIGHT) begin
            btn_dir = DIR_RIGHT;
        end else if (BTN_DOWN) begin
            btn_dir = DIR_DOWN;
        end else if (BTN_LEFT) begin
            btn_dir = DIR_LEFT;
        end
        // Checked against the committed direction, not the pending one, so a
        // quick two-press sequence inside one period cannot reverse the snake.
        capture_ok = btn_any && (btn_dir != (direction_q ^ 2'd2));
    end

    // Score-dependent period, clamped at the floor without unsigned underflow.
    always_comb begin
        score_sat      = (SCORE_COUNT > 4'd10) ? 32'd10 : 32'(SCORE_COUNT);
        dec_total      = score_sat * PERIOD_DEC;
        period_full    = (dec_total >= PERIOD_SPAN) ? MIN_PERIOD : (BASE_PERIOD - dec_total);
        period_m1_next = CNT_W'(period_full - 32'd1);
    end

    assign handshake = step_req_q && STEP_ACK;

    // Next-state logic: FSM, tick counter, handshake and direction commit.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        period_m1_d  = period_m1_q;
        pending_d    = pending_q;
        step_req_d   = 1'b0;
        step_dir_d   = step_dir_q;
        direction_d  = direction_q;
        step_count_d = step_count_q;

        if ((state_q != S_IDLE) && capture_ok) begin
            pending_d = btn_dir;
        end

        unique case (state_q)
            S_IDLE: begin
                counter_d    = '0;
                direction_d  = DIR_RIGHT;
                pending_d    = DIR_RIGHT;
                step_count_d = '0;
                if (mode_play) begin
                    state_d     = S_COUNT;
                    period_m1_d = period_m1_next;
                end
            end
            S_COUNT: begin
                if (mode_idle) begin
                    state_d = S_IDLE;
                end else if (mode_win) begin
                    state_d = S_HOLD;
                end else if (counter_q == period_m1_q) begin
                    state_d    = S_REQ;
                    counter_d  = '0;
                    step_req_d = 1'b1;
                    step_dir_d = pending_q;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            S_REQ: begin
                // Counter is parked while waiting, so a slow ACK stretches the period.
                step_req_d = 1'b1;
                // A completed handshake commits even if the master state is leaving PLAY.
                if (handshake) begin
                    direction_d  = step_dir_q;
                    step_count_d = step_count_q + 16'd1;
                end
                if (mode_idle) begin
                    state_d    = S_IDLE;
                    step_req_d = 1'b0;
                end else if (mode_win) begin
                    state_d    = S_HOLD;
                    step_req_d = 1'b0;
                end else if (handshake) begin
                    state_d     = S_COUNT;
                    step_req_d  = 1'b0;
                    counter_d   = '0;
                    period_m1_d = period_m1_next;
                end
            end
            S_HOLD: begin
                if (mode_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any in-flight request without committing.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            counter_q    <= '0;
            period_m1_q  <= '0;
            pending_q    <= DIR_RIGHT;
            step_req_q   <= 1'b0;
            step_dir_q   <= DIR_RIGHT;
            direction_q  <= DIR_RIGHT;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            period_m1_q  <= period_m1_d;
            pending_q    <= pending_d;
            step_req_q   <= step_req_d;
            step_dir_q   <= step_dir_d;
            direction_q  <= direction_d;
            step_count_q <= step_count_d;
        end
    end

    assign STEP_REQ   = step_req_q;
    assign STEP_DIR   = step_dir_q;
    assign DIRECTION  = direction_q;
    assign STEP_COUNT = step_count_q;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Directed bench for snake_step_scheduler with a shortened period
// (BASE_PERIOD=8, PERIOD_DEC=1, MIN_PERIOD=4).
module tb_snake_step_scheduler;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [1:0]  MASTER_STATE;
    logic [3:0]  SCORE_COUNT;
    logic        BTN_UP, BTN_RIGHT, BTN_DOWN, BTN_LEFT;
    logic        STEP_ACK;
    logic        STEP_REQ;
    logic [1:0]  STEP_DIR;
    logic [1:0]  DIRECTION;
    logic [15:0] STEP_COUNT;

    int total  = 0;
    int passed = 0;
    int n;

    snake_step_scheduler #(
        .BASE_PERIOD(8),
        .PERIOD_DEC (1),
        .MIN_PERIOD (4),
        .CNT_W      (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .MASTER_STATE(MASTER_STATE),
        .SCORE_COUNT (SCORE_COUNT),
        .BTN_UP      (BTN_UP),
        .BTN_RIGHT   (BTN_RIGHT),
        .BTN_DOWN    (BTN_DOWN),
        .BTN_LEFT    (BTN_LEFT),
        .STEP_ACK    (STEP_ACK),
        .STEP_REQ    (STEP_REQ),
        .STEP_DIR    (STEP_DIR),
        .DIRECTION   (DIRECTION),
        .STEP_COUNT  (STEP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Ticks until STEP_REQ is seen (bounded); returns the number of edges taken.
    task automatic wait_req(input string tag, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (STEP_REQ !== 1'b1 && cycles < 100);
        check(tag, 32'(STEP_REQ), 32'd1);
    endtask

    initial begin
        RESET = 1'b1;
        MASTER_STATE = 2'd0;
        SCORE_COUNT = 4'd0;
        {BTN_UP, BTN_RIGHT, BTN_DOWN, BTN_LEFT} = 4'b0000;
        STEP_ACK = 1'b1;
        #12;
        RESET = 1'b0;

        // Reset values
        check("rst_req", 32'(STEP_REQ), 32'd0);
        check("rst_step_dir", 32'(STEP_DIR), 32'd1);
        check("rst_direction", 32'(DIRECTION), 32'd1);
        check("rst_count", 32'(STEP_COUNT), 32'd0);

        // First request P+1 edges after PLAY, then steady 9-cycle spacing
        MASTER_STATE = 2'd1;
        wait_req("req1_seen", n);
        check("first_latency", n, 32'd9);
        check("req1_dir", 32'(STEP_DIR), 32'd1);
        wait_req("req2_seen", n);
        check("spacing_p8", n, 32'd9);
        check("count_after1", 32'(STEP_COUNT), 32'd1);
        check("dir_after1", 32'(DIRECTION), 32'd1);

        // Score-driven period changes, sampled at the counter restart
        SCORE_COUNT = 4'd2;
        wait_req("req3_seen", n);
        check("spacing_s2", n, 32'd7);
        SCORE_COUNT = 4'd6;
        wait_req("req4_seen", n);
        check("spacing_s6_floor", n, 32'd5);
        SCORE_COUNT = 4'd15;
        wait_req("req5_seen", n);
        check("spacing_s15_clamp", n, 32'd5);
        check("count_after4", 32'(STEP_COUNT), 32'd4);

        // LEFT while moving RIGHT is a reversal and is ignored
        BTN_LEFT = 1'b1;
        wait_req("req6_seen", n);
        check("left_blocked", 32'(STEP_DIR), 32'd1);
        BTN_LEFT = 1'b0;

        // UP and DOWN together: UP wins on priority
        BTN_UP = 1'b1;
        BTN_DOWN = 1'b1;
        wait_req("req7_seen", n);
        check("up_down_prio", 32'(STEP_DIR), 32'd0);
        BTN_UP = 1'b0;
        BTN_DOWN = 1'b0;
        tick();
        check("commit_up", 32'(DIRECTION), 32'd0);
        check("count_after7", 32'(STEP_COUNT), 32'd7);

        // After committing UP, LEFT is legal
        BTN_LEFT = 1'b1;
        wait_req("req8_seen", n);
        check("left_after_up", 32'(STEP_DIR), 32'd3);
        BTN_LEFT = 1'b0;

        // Slow ACK: request and direction held, no commit until ACK
        STEP_ACK = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("slow_req_hold", 32'(STEP_REQ), 32'd1);
            check("slow_dir_hold", 32'(STEP_DIR), 32'd3);
            check("slow_count_hold", 32'(STEP_COUNT), 32'd7);
        end
        STEP_ACK = 1'b1;
        tick();
        check("slow_commit_count", 32'(STEP_COUNT), 32'd8);
        check("slow_commit_dir", 32'(DIRECTION), 32'd3);
        check("slow_req_drop", 32'(STEP_REQ), 32'd0);

        // WIN during a pending request: abort without commit, then freeze
        wait_req("req9_seen", n);
        STEP_ACK = 1'b0;
        MASTER_STATE = 2'd2;
        tick();
        check("win_req_drop", 32'(STEP_REQ), 32'd0);
        check("win_dir_frozen", 32'(DIRECTION), 32'd3);
        check("win_count_frozen", 32'(STEP_COUNT), 32'd8);
        STEP_ACK = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("win_no_req", 32'(STEP_REQ), 32'd0);
        end
        check("win_count_still", 32'(STEP_COUNT), 32'd8);

        // Back to IDLE clears direction and step count
        MASTER_STATE = 2'd0;
        tick();
        tick();
        check("idle_dir", 32'(DIRECTION), 32'd1);
        check("idle_count", 32'(STEP_COUNT), 32'd0);
        check("idle_req", 32'(STEP_REQ), 32'd0);

        // Re-enter PLAY at the floor period; UP then LEFT within one period
        MASTER_STATE = 2'd1;
        wait_req("replay_req_seen", n);
        check("replay_latency", n, 32'd5);
        check("replay_dir", 32'(STEP_DIR), 32'd1);
        BTN_UP = 1'b1;
        tick();
        BTN_UP = 1'b0;
        BTN_LEFT = 1'b1;
        tick();
        BTN_LEFT = 1'b0;
        wait_req("quick_req_seen", n);
        check("quick_up_left", 32'(STEP_DIR), 32'd0);
        check("quick_dir_committed", 32'(DIRECTION), 32'd1);
        check("quick_count", 32'(STEP_COUNT), 32'd1);

        // Asynchronous reset in the middle of a handshake
        STEP_ACK = 1'b0;
        #3;
        RESET = 1'b1;
        #1;
        check("async_req", 32'(STEP_REQ), 32'd0);
        check("async_step_dir", 32'(STEP_DIR), 32'd1);
        check("async_direction", 32'(DIRECTION), 32'd1);
        check("async_count", 32'(STEP_COUNT), 32'd0);
        RESET = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
